// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz VGA raster timing (pixel enable, H/V counters, syncs, markers).
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 515
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] H_Counter_Value,
  output logic [15:0] V_Counter_Value,
  output logic        Hsync,
  output logic        Vsync,
  output logic        pixel_tick,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);
  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [15:0] H_MAX   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_MAX   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SW    = 16'(H_SYNC);
  localparam logic [15:0] V_SW    = 16'(V_SYNC);
  localparam logic [15:0] H_AS    = 16'(H_ACT_START);
  localparam logic [15:0] H_AE    = 16'(H_ACT_END);
  localparam logic [15:0] V_AS    = 16'(V_ACT_START);
  localparam logic [15:0] V_AE    = 16'(V_ACT_END);
  logic [15:0] div_cnt;
  logic        h_wrap, v_wrap;
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt         <= '0;
      H_Counter_Value <= '0;
      V_Counter_Value <= '0;
    end else begin
      div_cnt <= pixel_tick ? '0 : div_cnt + 16'd1;
      if (pixel_tick) begin
        H_Counter_Value <= h_wrap ? '0 : H_Counter_Value + 16'd1;
        if (h_wrap) V_Counter_Value <= v_wrap ? '0 : V_Counter_Value + 16'd1;
      end
    end
  end
  // every output is a pure decode of the registered counters
  always_comb begin
    pixel_tick  = div_cnt == DIV_MAX;
    h_wrap      = H_Counter_Value == H_MAX;
    v_wrap      = V_Counter_Value == V_MAX;
    Hsync       = H_Counter_Value >= H_SW;
    Vsync       = V_Counter_Value >= V_SW;
    video_on    = H_Counter_Value >= H_AS && H_Counter_Value < H_AE &&
                  V_Counter_Value >= V_AS && V_Counter_Value < V_AE;
    line_start  = H_Counter_Value == '0 && div_cnt == '0;
    frame_start = line_start && V_Counter_Value == '0;
  end
`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) frame_count <= '0;
    else if (pixel_tick && h_wrap && v_wrap) frame_count <= frame_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-reset stimulus against a cycle-count reference model, on a
// full-size instance and a shrunken raster instance that completes frames quickly.
module tb_vga_timing_gen;
  localparam int SH = 40, SHS = 5, SHA = 8, SHE = 36, SV = 20, SVS = 2, SVA = 4, SVE = 18;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [15:0] d_h, d_v, s_h, s_v;
  logic d_hs, d_vs, d_tk, d_von, d_ls, d_fs;
  logic s_hs, s_vs, s_tk, s_von, s_ls, s_fs;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] d_fc, s_fc;
`endif
  vga_timing_gen dut_d (
    .clk(clk), .reset(reset), .H_Counter_Value(d_h), .V_Counter_Value(d_v),
    .Hsync(d_hs), .Vsync(d_vs), .pixel_tick(d_tk), .video_on(d_von),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(d_fc)
`endif
  );
  vga_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(SH), .H_SYNC(SHS), .H_ACT_START(SHA), .H_ACT_END(SHE),
    .V_TOTAL(SV), .V_SYNC(SVS), .V_ACT_START(SVA), .V_ACT_END(SVE)
  ) dut_s (
    .clk(clk), .reset(reset), .H_Counter_Value(s_h), .V_Counter_Value(s_v),
    .Hsync(s_hs), .Vsync(s_vs), .pixel_tick(s_tk), .video_on(s_von),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(s_fc)
`endif
  );
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Position is a pure function of clocks elapsed since reset was last sampled high.
  function automatic logic [37:0] model(int t, int ht, int hsw, int has, int hae,
                                        int vt, int vsw, int vas, int vae);
    int d = t % 4;
    int p = t / 4;
    int h = p % ht;
    int v = (p / ht) % vt;
    logic [15:0] hh = 16'(h);
    logic [15:0] vv = 16'(v);
    return {hh, vv, h >= hsw, v >= vsw, d == 3,
            (h >= has && h < hae && v >= vas && v < vae), h == 0 && d == 0,
            h == 0 && v == 0 && d == 0};
  endfunction
  int t = 0;
  bit go = 0;
  always @(posedge clk) t <= reset ? 0 : t + 1;
  always @(negedge clk) if (go) begin
    chk("d_outs", {26'd0, d_h, d_v, d_hs, d_vs, d_tk, d_von, d_ls, d_fs},
        {26'd0, model(t, 800, 96, 144, 784, 525, 2, 35, 515)});
    chk("s_outs", {26'd0, s_h, s_v, s_hs, s_vs, s_tk, s_von, s_ls, s_fs},
        {26'd0, model(t, SH, SHS, SHA, SHE, SV, SVS, SVA, SVE)});
`ifdef VGA_FRAME_COUNT_EN
    chk("d_fcnt", {48'd0, d_fc}, 64'd0);
    chk("s_fcnt", {48'd0, s_fc}, 64'(16'(t / (4 * SH * SV))));
`endif
  end
  // Period and duty measurements between consecutive markers, restarted by any reset.
  int cyc = 0, ls_last = -1, fs_last = -1, tk_cnt = 0, hs_cnt = 0, von_cnt = 0, vs_cnt = 0;
  always @(negedge clk) begin
    cyc++;
    if (reset || !go) begin
      ls_last = -1; fs_last = -1; tk_cnt = 0; hs_cnt = 0; von_cnt = 0; vs_cnt = 0;
    end else begin
      if (d_ls) begin
        if (ls_last >= 0) begin
          chk("line_period", 64'(cyc - ls_last), 64'd3200);
          chk("ticks_per_line", 64'(tk_cnt), 64'd800);
          chk("hsync_low_clk", 64'(hs_cnt), 64'd384);
        end
        ls_last = cyc; tk_cnt = 0; hs_cnt = 0;
      end
      if (s_fs) begin
        if (fs_last >= 0) begin
          chk("frame_period", 64'(cyc - fs_last), 64'(4 * SH * SV));
          chk("von_ticks", 64'(von_cnt), 64'((SHE - SHA) * (SVE - SVA)));
          chk("vsync_low_clk", 64'(vs_cnt), 64'(4 * SH * SVS));
        end
        fs_last = cyc; von_cnt = 0; vs_cnt = 0;
      end
      tk_cnt += int'(d_tk);
      hs_cnt += int'(!d_hs);
      von_cnt += int'(s_von && s_tk);
      vs_cnt += int'(!s_vs);
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    step(5);
    go = 1;
    chk("rst_h", {48'd0, d_h}, 64'd0);
    chk("rst_v", {48'd0, d_v}, 64'd0);
    chk("rst_syncs", {62'd0, d_hs, d_vs}, 64'd0);
    chk("rst_von_tick", {62'd0, d_von, d_tk}, 64'd0);
    chk("rst_markers", {62'd0, d_ls, d_fs}, 64'd3);
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("no_early_tick", {63'd0, d_tk}, 64'd0);
    @(negedge clk);
    chk("first_tick", {63'd0, d_tk}, 64'd1);
    @(negedge clk);
    chk("h_after_tick", {48'd0, d_h}, 64'd1);
    step(7000);
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(50, 900));
      reset = 1;
      step($urandom_range(1, 3));
      reset = 0;
    end
    begin
      int n = 0;
      while (s_h != 16'd20 && n < 1000) begin
        step(1);
        n++;
      end
      chk("wait_h20", {63'd0, s_h == 16'd20}, 64'd1);
    end
    reset = 1;
    step(1);
    reset = 0;
    chk("mid_rst_hv", {32'd0, s_h, s_v}, 64'd0);
    chk("mid_rst_div", {48'd0, dut_s.div_cnt}, 64'd0);
    step(4 * SH * SV * 5 + 100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
